// File: rtl/atomic_cnt_pkg.sv
// Shared defaults and snapshot-state encoding for the atomic counter bank.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package atomic_cnt_pkg;

   localparam int DEF_NUM_CH   = 4;
   localparam int DEF_COUNTLEN = 64;
   localparam int DEF_DATABUS  = 32;
   localparam int DEF_SATURATE = 0;

   typedef enum logic {
      EMPTY  = 1'b0,
      LOADED = 1'b1
   } snap_state_t;

endpackage

// File: rtl/atomic_cnt_channel.sv
// One event counter: sync clear, increment with wrap or saturate, sticky overflow flag.
// Latency: count/ovf update on the edge that samples trig/clr.
// Backpressure: none, one increment accepted every cycle.
module atomic_cnt_channel #(
   parameter int COUNTLEN = 64,
   parameter int SATURATE = 0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                trig,
   input  logic                clr,
   output logic [COUNTLEN-1:0] count,
   output logic                ovf
);

   logic all_ones;
   assign all_ones = &count;

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         count <= '0;
         ovf   <= 1'b0;
      end else if (trig) begin
         // At all-ones the increment either rolls over naturally or is held.
         if (all_ones) begin
            ovf <= 1'b1;
         end
         if (!(all_ones && (SATURATE != 0))) begin
            count <= count + COUNTLEN'(1);
         end
      end
   end

endmodule

// File: rtl/atomic_counter_bank.sv
// Bank of wide counters read atomically through a narrow bus via a word-0 snapshot.
// Latency: response registered, ack one cycle after the request edge.
// Backpressure: none, a request is accepted every cycle.
module atomic_counter_bank
   import atomic_cnt_pkg::*;
#(
   parameter int NUM_CH   = DEF_NUM_CH,
   parameter int COUNTLEN = DEF_COUNTLEN,
   parameter int DATABUS  = DEF_DATABUS,
   parameter int SATURATE = DEF_SATURATE,
   localparam int NWORDS  = COUNTLEN / DATABUS,
   localparam int CHW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int WSW     = $clog2(NWORDS)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_CH-1:0]  trig_i,
   input  logic [NUM_CH-1:0]  clr_i,
   input  logic               req_i,
   input  logic [CHW-1:0]     ch_sel_i,
   input  logic [WSW-1:0]     word_sel_i,
   output logic               ack_o,
   output logic [DATABUS-1:0] count_o,
   output logic               err_o,
   output logic [NUM_CH-1:0]  ovf_o
);

   if ((COUNTLEN % DATABUS) != 0 || COUNTLEN < 2 * DATABUS) begin : g_bad_width
      $error("atomic_counter_bank: COUNTLEN must be a multiple of DATABUS and >= 2*DATABUS");
   end
   if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
      $error("atomic_counter_bank: NUM_CH must be in 1..16");
   end

   typedef logic [NWORDS-1:0][DATABUS-1:0] words_t;

   typedef struct packed {
      logic               ack;
      logic               err;
      logic [DATABUS-1:0] dat;
   } rsp_t;

   logic [COUNTLEN-1:0] cnt [NUM_CH];

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      atomic_cnt_channel #(
         .COUNTLEN (COUNTLEN),
         .SATURATE (SATURATE)
      ) u_ch (
         .clk   (clk),
         .reset (reset),
         .trig  (trig_i[c]),
         .clr   (clr_i[c]),
         .count (cnt[c]),
         .ovf   (ovf_o[c])
      );
   end

   logic [COUNTLEN-1:0] sel_cnt;
   logic                ch_ok;
   logic                word_ok;
   logic                word0;
   logic                cap;
   logic                hit;

   snap_state_t         state_q;
   snap_state_t         state_d;
   words_t              snap_q;
   logic [CHW-1:0]      snap_ch_q;
   rsp_t                rsp_d;
   rsp_t                rsp_q;

   always_comb begin
      sel_cnt = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (ch_sel_i == CHW'(c)) begin
            sel_cnt = cnt[c];
         end
      end
   end

   assign ch_ok   = {1'b0, ch_sel_i} < (CHW + 1)'(NUM_CH);
   assign word_ok = {1'b0, word_sel_i} < (WSW + 1)'(NWORDS);
   assign word0   = (word_sel_i == '0);
   assign cap     = req_i && ch_ok && word0;
   assign hit     = req_i && ch_ok && !word0 && word_ok &&
                    (state_q == LOADED) && (ch_sel_i == snap_ch_q);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (cap) begin
         state_d = LOADED;
      end
   end

   // Snapshot sees the pre-edge count, so a word-0 read never includes its own cycle's increment.
   always_ff @(posedge clk) begin
      if (reset) begin
         snap_q    <= '0;
         snap_ch_q <= '0;
      end else if (cap) begin
         snap_q    <= sel_cnt;
         snap_ch_q <= ch_sel_i;
      end
   end

   always_comb begin
      rsp_d     = '0;
      rsp_d.ack = req_i;
      if (cap) begin
         rsp_d.dat = sel_cnt[DATABUS-1:0];
      end else if (hit) begin
         rsp_d.dat = snap_q[word_sel_i];
      end else if (req_i) begin
         rsp_d.err = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_q <= '0;
      end else begin
         rsp_q <= rsp_d;
      end
   end

   assign ack_o   = rsp_q.ack;
   assign err_o   = rsp_q.err;
   assign count_o = rsp_q.dat;

endmodule

// File: tb/tb_atomic_counter_bank.sv
// Scoreboarded bench: a default 64/32 bank plus two small 12/4 banks (wrap and saturate).
module tb_atomic_counter_bank;

   typedef struct {
      logic [31:0] dat;
      logic        err;
      int          due;
   } exp_t;

   exp_t  q[3][$];
   string nm[3] = '{"main", "wrap", "sat"};
   int    vectors     = 0;
   int    miscompares = 0;
   int    cyc         = 0;
   bit    mon_en      = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // default-parameter bank
   logic        reset;
   logic [3:0]  trig, clr;
   logic        req;
   logic [1:0]  ch;
   logic [0:0]  word;
   logic        ack, err;
   logic [31:0] cnt_o;
   logic [3:0]  ovf;

   // small banks: 3 channels, 12-bit counters, 4-bit bus, 3 words
   logic        s_reset;
   logic [2:0]  s_trig, s_clr;
   logic        s_req;
   logic [1:0]  s_ch, s_word;
   logic        w_ack, w_err, s_ack, s_err;
   logic [3:0]  w_cnt, s_cnt;
   logic [2:0]  w_ovf, s_ovf;

   atomic_counter_bank u_main (
      .clk(clk), .reset(reset), .trig_i(trig), .clr_i(clr), .req_i(req),
      .ch_sel_i(ch), .word_sel_i(word), .ack_o(ack), .count_o(cnt_o),
      .err_o(err), .ovf_o(ovf)
   );

   atomic_counter_bank #(.NUM_CH(3), .COUNTLEN(12), .DATABUS(4), .SATURATE(0)) u_wrap (
      .clk(clk), .reset(s_reset), .trig_i(s_trig), .clr_i(s_clr), .req_i(s_req),
      .ch_sel_i(s_ch), .word_sel_i(s_word), .ack_o(w_ack), .count_o(w_cnt),
      .err_o(w_err), .ovf_o(w_ovf)
   );

   atomic_counter_bank #(.NUM_CH(3), .COUNTLEN(12), .DATABUS(4), .SATURATE(1)) u_sat (
      .clk(clk), .reset(s_reset), .trig_i(s_trig), .clr_i(s_clr), .req_i(s_req),
      .ch_sel_i(s_ch), .word_sel_i(s_word), .ack_o(s_ack), .count_o(s_cnt),
      .err_o(s_err), .ovf_o(s_ovf)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cyc %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic expect_rsp(input int k, input logic [31:0] d, input logic e);
      exp_t x;
      x.dat = d;
      x.err = e;
      x.due = cyc + 1;
      q[k].push_back(x);
   endtask

   task automatic rd_main(input int c, input int w, input logic [31:0] d, input logic e);
      req  = 1'b1;
      ch   = 2'(c);
      word = 1'(w);
      expect_rsp(0, d, e);
   endtask

   task automatic rd_small(input int c, input int w, input logic [31:0] dw,
                           input logic [31:0] ds, input logic e);
      s_req  = 1'b1;
      s_ch   = 2'(c);
      s_word = 2'(w);
      expect_rsp(1, dw, e);
      expect_rsp(2, ds, e);
   endtask

   task automatic mon(input int k, input logic a, input logic [31:0] d, input logic e);
      exp_t x;
      vectors++;
      if (a) begin
         if (q[k].size() == 0) begin
            miscompares++;
            $display("FAIL %s unexpected_ack: got ack=1 data=0x%0h err=%0b, expected ack=0 (cyc %0d)",
                     nm[k], d, e, cyc);
         end else begin
            x = q[k].pop_front();
            if (d !== x.dat || e !== x.err || cyc != x.due) begin
               miscompares++;
               $display("FAIL %s response: got data=0x%0h err=%0b at cyc %0d, expected data=0x%0h err=%0b at cyc %0d",
                        nm[k], d, e, cyc, x.dat, x.err, x.due);
            end
         end
      end else begin
         if (d !== 32'h0 || e !== 1'b0) begin
            miscompares++;
            $display("FAIL %s idle_outputs: got data=0x%0h err=%0b, expected 0/0 (cyc %0d)", nm[k], d, e, cyc);
         end else if (q[k].size() > 0 && q[k][0].due <= cyc) begin
            x = q[k].pop_front();
            miscompares++;
            $display("FAIL %s missing_ack: got ack=0, expected ack with data=0x%0h err=%0b (cyc %0d)",
                     nm[k], x.dat, x.err, cyc);
         end
      end
   endtask

   task automatic monitor_loop();
      forever begin
         @(negedge clk);
         if (mon_en) begin
            mon(0, ack, cnt_o, err);
            mon(1, w_ack, 32'(w_cnt), w_err);
            mon(2, s_ack, 32'(s_cnt), s_err);
         end
      end
   endtask

   initial begin
      reset = 1'b1; trig = '0; clr = '0; req = 1'b0; ch = '0; word = '0;
      s_reset = 1'b1; s_trig = '0; s_clr = '0; s_req = 1'b0; s_ch = '0; s_word = '0;
      fork
         monitor_loop();
      join_none
      repeat (2) tick();
      reset = 1'b0;
      s_reset = 1'b0;

      chk("reset_ack", 32'(ack), 32'h0);
      chk("reset_count", cnt_o, 32'h0);
      chk("reset_err", 32'(err), 32'h0);
      chk("reset_ovf", 32'(ovf), 32'h0);
      chk("reset_small_ovf", 32'({w_ovf, s_ovf}), 32'h0);
      mon_en = 1'b1;

      // five increments on ch1, then low word and high word of its snapshot
      trig = 4'b0010;
      repeat (5) tick();
      trig = '0;
      rd_main(1, 0, 32'd5, 1'b0); tick();
      rd_main(1, 1, 32'd0, 1'b0); tick();
      req = 1'b0;
      chk("ovf_after_count", 32'(ovf), 32'h0);

      // small ch2 reaches 0x00F with trig still high; word1 must come from the snapshot (0), not live (1)
      s_trig = 3'b100;
      repeat (15) tick();
      rd_small(2, 0, 32'hF, 32'hF, 1'b0); tick();
      rd_small(2, 1, 32'h0, 32'h0, 1'b0); tick();
      rd_small(2, 2, 32'h0, 32'h0, 1'b0); tick();
      s_req = 1'b0;
      s_trig = '0;

      // ch0 to all-ones, then one more increment: wrap vs saturate
      s_trig = 3'b001;
      repeat (4095) tick();
      s_trig = '0;
      chk("ovf_at_all_ones_wrap", 32'(w_ovf), 32'h0);
      chk("ovf_at_all_ones_sat", 32'(s_ovf), 32'h0);
      rd_small(0, 0, 32'hF, 32'hF, 1'b0); tick();
      rd_small(0, 2, 32'hF, 32'hF, 1'b0); tick();
      s_req = 1'b0;
      s_trig = 3'b001; tick();
      s_trig = '0;
      chk("ovf_after_wrap", 32'(w_ovf), 32'h1);
      chk("ovf_after_sat", 32'(s_ovf), 32'h1);
      rd_small(0, 0, 32'h0, 32'hF, 1'b0); tick();
      rd_small(0, 1, 32'h0, 32'hF, 1'b0); tick();
      rd_small(0, 3, 32'h0, 32'h0, 1'b1); tick();
      rd_small(3, 0, 32'h0, 32'h0, 1'b1); tick();
      rd_small(0, 1, 32'h0, 32'hF, 1'b0); tick();
      s_req = 1'b0;
      s_trig = 3'b001; tick();
      s_trig = '0;
      chk("ovf_sticky_wrap", 32'(w_ovf), 32'h1);
      chk("ovf_sticky_sat", 32'(s_ovf), 32'h1);
      s_trig = 3'b001; s_clr = 3'b001; tick();
      s_trig = '0; s_clr = '0;
      chk("clr_beats_trig_wrap", 32'(w_ovf), 32'h0);
      chk("clr_beats_trig_sat", 32'(s_ovf), 32'h0);
      rd_small(0, 0, 32'h0, 32'h0, 1'b0); tick();
      s_req = 1'b0;

      // after reset: word1 with no snapshot errors; word1 on a different channel errors
      reset = 1'b1; tick();
      reset = 1'b0;
      rd_main(0, 1, 32'h0, 1'b1); tick();
      rd_main(0, 0, 32'h0, 1'b0); tick();
      rd_main(3, 1, 32'h0, 1'b1); tick();
      rd_main(0, 1, 32'h0, 1'b0); tick();
      req = 1'b0; tick();

      // back-to-back alternating word0/word1 on ch0 while it counts
      trig = 4'b0001;
      rd_main(0, 0, 32'd0, 1'b0); tick();
      rd_main(0, 1, 32'd0, 1'b0); tick();
      rd_main(0, 0, 32'd2, 1'b0); tick();
      rd_main(0, 1, 32'd0, 1'b0); tick();
      trig = '0;

      // reset lands mid-stream with a request and a trig on the same edge
      rd_main(0, 0, 32'd4, 1'b0); tick();
      reset = 1'b1; req = 1'b1; ch = 2'd0; word = 1'b0; trig = 4'b0001;
      tick();
      reset = 1'b0; trig = '0;
      chk("reset_edge_ack", 32'(ack), 32'h0);
      chk("reset_edge_count", cnt_o, 32'h0);
      chk("reset_edge_err", 32'(err), 32'h0);
      chk("reset_edge_ovf", 32'(ovf), 32'h0);
      rd_main(0, 1, 32'h0, 1'b1); tick();
      rd_main(0, 0, 32'h0, 1'b0); tick();
      req = 1'b0;

      repeat (4) tick();
      for (int k = 0; k < 3; k++) begin
         chk({nm[k], "_pending_responses"}, 32'(q[k].size()), 32'h0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/atomic_counter_bank.md
ATOMIC_COUNTER_BANK -- requirements
Module: atomic_counter_bank

Interface
REQ-001 Parameters SHALL be: NUM_CH, default 4, number of independent counters (1..16).
REQ-002 Parameters SHALL be: COUNTLEN, default 64, counter width in bits.
REQ-003 Parameters SHALL be: DATABUS, default 32, read-data width; COUNTLEN SHALL be an integer multiple of DATABUS and at least 2*DATABUS (elaboration error otherwise).
REQ-004 Parameters SHALL be: SATURATE, default 0, 0 = wrap at max, 1 = hold at all-ones.
REQ-005 Derived constants SHALL be: NWORDS = COUNTLEN/DATABUS; CHW = max(1,clog2(NUM_CH)); WSW = clog2(NWORDS).
REQ-006 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-007 reset  input  1  reset is synchronous and active-high.
REQ-008 trig_i  input  NUM_CH  per-channel increment enable, one increment per cycle when high.
REQ-009 clr_i  input  NUM_CH  per-channel synchronous clear of counter and overflow flag.
REQ-010 req_i  input  1  read request strobe, sampled every cycle.
REQ-011 ch_sel_i  input  CHW  channel addressed by the request.
REQ-012 word_sel_i  input  WSW  DATABUS-wide word addressed (0 = least significant).
REQ-013 ack_o  output  1  read response valid, one cycle wide.
REQ-014 count_o  output  DATABUS  read data, valid when ack_o high.
REQ-015 err_o  output  1  read error, valid when ack_o high.
REQ-016 ovf_o  output  NUM_CH  sticky per-channel overflow flag.

Function
REQ-017 Each channel counter SHALL update as: clr_i -> 0; else trig_i -> +1 (wrap or saturate per SATURATE); else hold; clr_i SHALL win over a simultaneous trig_i.
REQ-018 ovf_o[c] SHALL set on the edge where counter c wraps (SATURATE=0) or where an increment is attempted at all-ones (SATURATE=1), and SHALL clear only on clr_i[c] or reset; clr_i wins over a simultaneous overflow.
REQ-019 A request sampled at edge N SHALL produce ack_o=1 for exactly the cycle after edge N; back-to-back requests every cycle SHALL be accepted, one response per request, no stall.
REQ-020 ack_o SHALL be 0 when no request was sampled at the previous edge; count_o and err_o SHALL then be 0.
REQ-021 A word_sel_i=0 request SHALL capture the full COUNTLEN-bit register value of channel ch_sel_i as it stood before edge N (excluding that edge's increment/clear) into a single snapshot register, record the channel, set snapshot-valid, and return the low word.
REQ-022 A word_sel_i=k>0 request SHALL return snapshot word k when snapshot-valid is set and ch_sel_i equals the recorded channel, with err_o=0.
REQ-023 A word_sel_i>0 request with snapshot invalid, channel mismatch, or word_sel_i>=NWORDS SHALL return count_o=0, err_o=1, and SHALL NOT alter the snapshot.
REQ-024 A request with ch_sel_i>=NUM_CH SHALL return count_o=0, err_o=1, no snapshot change.
REQ-025 The snapshot SHALL remain valid and unchanged until the next successful word-0 request; counter activity and clr_i SHALL NOT modify it.
REQ-026 Snapshot handling SHALL be a two-state machine: EMPTY (after reset) -> LOADED on any valid word-0 request; LOADED -> LOADED on re-capture; no other transitions except reset.

Reset
REQ-027 reset SHALL be synchronous: all counters, ovf_o, snapshot, recorded channel SHALL go to 0, state SHALL go to EMPTY, and ack_o, err_o, count_o SHALL be 0 in the cycle after the reset edge.
REQ-028 A request sampled on the same edge as reset SHALL be dropped (no ack); trig_i/clr_i on that edge SHALL be ignored.

Structure
REQ-029 A package atomic_cnt_pkg SHALL hold the default parameter constants and the snapshot-state enum (EMPTY, LOADED).
REQ-030 One sub-module atomic_cnt_channel SHALL implement a single counter with clear, increment, SATURATE and overflow flag; the top SHALL instantiate it NUM_CH times via generate.
REQ-031 The top SHALL hold only request decode, snapshot register/FSM and the registered response stage.

Verification
REQ-032 Defaults; trig_i[1] high 5 cycles, read ch1 word0 then word1 -> ack each next cycle, count_o=5 then 0, err_o=0.
REQ-033 Preload ch2 to 0x0000_0000_FFFF_FFFF via increments (COUNTLEN=40/DATABUS=8 variant acceptable), keep trig_i[2] high, read word0 then word1 -> word1 reflects the snapshot (0x0), not the live carried value.
REQ-034 Reset, then read ch0 word1 -> err_o=1, count_o=0; read ch0 word0 then ch3 word1 -> second response err_o=1.
REQ-035 SATURATE=0, COUNTLEN=64 counter forced to all-ones then one trig -> counter 0, ovf_o set; SATURATE=1 -> stays all-ones, ovf_o set; clr_i same cycle as trig -> 0, ovf_o 0.
REQ-036 req_i high 4 consecutive cycles alternating word0/word1 on ch0 with trig_i[0] high -> 4 acks, each word1 pairs with the preceding word0 snapshot.
REQ-037 Assert reset mid-stream with req_i high -> no ack in the following cycle, all outputs 0, subsequent word1 read errors.
